// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: opcode classes, stage-entry layout,
// decode classification bundle and the forwarding-select width helper.
package rv_pkg;

   // Opcode class taken from inst[6:2]
   typedef enum logic [4:0] {
      OP_LOAD   = 5'd0,
      OP_I      = 5'd4,
      OP_AUIPC  = 5'd5,
      OP_STORE  = 5'd8,
      OP_R      = 5'd12,
      OP_LUI    = 5'd13,
      OP_BRANCH = 5'd24,
      OP_JALR   = 5'd25,
      OP_JAL    = 5'd27,
      OP_CSRW   = 5'd28
   } opcode_e;

   // One in-flight producer slot
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       is_load;
   } stage_entry_t;

   // Register usage of one instruction
   typedef struct packed {
      logic uses_rs1;
      logic uses_rs2;
      logic writes_rd;
      logic is_load;
      logic is_csrw;
   } inst_class_t;

   // Width of a select that encodes 0 (regfile) or stage 1..stages
   function automatic int fwd_sel_w(input int stages);
      return (stages < 1) ? 1 : $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side bus of the forwarding/hazard controller. The controller sits
// on the slave modport; the pipeline (or a bench) drives the master side.
interface fwd_hazard_ctrl_if #(
   parameter int STAGES = 2,
   parameter int CNT_W  = 32
);
   localparam int SEL_W = rv_pkg::fwd_sel_w(STAGES);

   logic [31:0]      id_inst;
   logic             id_valid;
   logic             redirect;
   logic             ext_stall;
   logic [SEL_W-1:0] fwd_rs1_sel;
   logic [SEL_W-1:0] fwd_rs2_sel;
   logic             id_stall;
   logic             ex_bubble;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_inst, id_valid, redirect, ext_stall,
      input  fwd_rs1_sel, fwd_rs2_sel, id_stall, ex_bubble, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_inst, id_valid, redirect, ext_stall,
      output fwd_rs1_sel, fwd_rs2_sel, id_stall, ex_bubble, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/rv_inst_class.sv
// Combinational opcode decode: which sources an instruction reads, whether it
// produces a register result, and whether that result comes from a load.
module rv_inst_class
   import rv_pkg::*;
(
   input  logic [31:0] inst,
   output inst_class_t cls
);

   logic [4:0] opc;
   logic       rd_nz;
   logic       unused_inst_bits;

   assign opc   = inst[6:2];
   assign rd_nz = (inst[11:7] != 5'd0);

   // Only the opcode and rd fields matter for classification
   assign unused_inst_bits = ^{inst[31:12], inst[1:0]};

   // Opcode table; unknown opcodes read nothing and write nothing
   always_comb begin
      cls = '0;
      case (opcode_e'(opc))
         OP_LOAD: begin
            cls.uses_rs1  = 1'b1;
            cls.writes_rd = rd_nz;
            cls.is_load   = 1'b1;
         end
         OP_STORE, OP_BRANCH: begin
            cls.uses_rs1 = 1'b1;
            cls.uses_rs2 = 1'b1;
         end
         OP_JALR, OP_I: begin
            cls.uses_rs1  = 1'b1;
            cls.writes_rd = rd_nz;
         end
         OP_R: begin
            cls.uses_rs1  = 1'b1;
            cls.uses_rs2  = 1'b1;
            cls.writes_rd = rd_nz;
         end
         OP_JAL, OP_AUIPC, OP_LUI: begin
            cls.writes_rd = rd_nz;
         end
         OP_CSRW: begin
            cls.uses_rs1 = 1'b1;
            cls.is_csrw  = 1'b1;
         end
         default: cls = '0;
      endcase
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller. Keeps one {valid, rd, is_load} slot per
// post-decode stage, picks the youngest producer for each decode source,
// raises load-use stalls and handles redirect flushes with event counters.
module fwd_hazard_ctrl
   import rv_pkg::*;
#(
   parameter int STAGES     = 2,
   parameter int LOAD_LAT   = 1,
   parameter int CSR_X0_FWD = 1,
   parameter int CNT_W      = 32
) (
   input logic              clk,
   input logic              rst,
   fwd_hazard_ctrl_if.slave bus
);

   localparam int SEL_W = fwd_sel_w(STAGES);

   inst_class_t              cls;
   logic [4:0]               rs1;
   logic [4:0]               rs2;
   logic [4:0]               rd;
   logic                     rs1_ok;
   logic                     rs2_ok;
   logic [STAGES:1]          match_rs1;
   logic [STAGES:1]          match_rs2;
   logic [SEL_W-1:0]         rs1_sel;
   logic [SEL_W-1:0]         rs2_sel;
   logic                     rs1_load_use;
   logic                     rs2_load_use;
   logic                     id_stall;
   logic                     ex_bubble;

   stage_entry_t [STAGES:1]  entries_q;
   stage_entry_t [STAGES:1]  entries_d;
   logic [CNT_W-1:0]         stall_cnt_q;
   logic [CNT_W-1:0]         stall_cnt_d;
   logic [CNT_W-1:0]         flush_cnt_q;
   logic [CNT_W-1:0]         flush_cnt_d;

   rv_inst_class u_inst_class (
      .inst (bus.id_inst),
      .cls  (cls)
   );

   assign rs1 = bus.id_inst[19:15];
   assign rs2 = bus.id_inst[24:20];
   assign rd  = bus.id_inst[11:7];

   // x0 is never a forwarding target, apart from the legacy CSRW rs1 case
   // (which cannot actually hit because rd=0 producers are never valid)
   assign rs1_ok = cls.uses_rs1 &&
                   ((rs1 != 5'd0) || ((CSR_X0_FWD != 0) && cls.is_csrw));
   assign rs2_ok = cls.uses_rs2 && (rs2 != 5'd0);

   genvar gi;
   generate
      for (gi = 1; gi <= STAGES; gi++) begin : g_match
         assign match_rs1[gi] = rs1_ok && entries_q[gi].valid && (entries_q[gi].rd == rs1);
         assign match_rs2[gi] = rs2_ok && entries_q[gi].valid && (entries_q[gi].rd == rs2);
      end
   endgenerate

   // Youngest producer wins: scan oldest to youngest so the smallest k sticks
   always_comb begin
      rs1_sel      = '0;
      rs2_sel      = '0;
      rs1_load_use = 1'b0;
      rs2_load_use = 1'b0;
      for (int k = STAGES; k >= 1; k--) begin
         if (match_rs1[k]) begin
            rs1_sel      = SEL_W'(k);
            rs1_load_use = entries_q[k].is_load && (k <= LOAD_LAT);
         end
         if (match_rs2[k]) begin
            rs2_sel      = SEL_W'(k);
            rs2_load_use = entries_q[k].is_load && (k <= LOAD_LAT);
         end
      end
   end

   // A redirect kills the decode instruction, so it never waits on a load
   always_comb begin
      id_stall  = (rs1_load_use || rs2_load_use) && !bus.redirect;
      ex_bubble = id_stall || bus.redirect || !bus.id_valid;
   end

   // Shift the producer pipe and count events unless the core is frozen
   always_comb begin
      entries_d   = entries_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!bus.ext_stall) begin
         for (int k = STAGES; k >= 2; k--) begin
            entries_d[k] = entries_q[k-1];
         end
         entries_d[1].valid   = bus.id_valid && !id_stall && !bus.redirect && cls.writes_rd;
         entries_d[1].rd      = rd;
         entries_d[1].is_load = cls.is_load;
         if (id_stall) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (bus.redirect) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entries_q   <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         entries_q   <= entries_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.fwd_rs1_sel = rs1_sel;
   assign bus.fwd_rs2_sel = rs2_sel;
   assign bus.id_stall    = id_stall;
   assign bus.ex_bubble   = ex_bubble;
   assign bus.stall_cnt   = stall_cnt_q;
   assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a 2-stage/LOAD_LAT=1 instance and a
// 4-stage/LOAD_LAT=2 instance, with hand-computed selects, stalls and counts.
module tb_fwd_hazard_ctrl;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   fwd_hazard_ctrl_if #(.STAGES(2), .CNT_W(32)) b2 ();
   fwd_hazard_ctrl_if #(.STAGES(4), .CNT_W(32)) b4 ();

   fwd_hazard_ctrl #(.STAGES(2), .LOAD_LAT(1), .CSR_X0_FWD(1), .CNT_W(32)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (b2)
   );

   fwd_hazard_ctrl #(.STAGES(4), .LOAD_LAT(2), .CSR_X0_FWD(1), .CNT_W(32)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (b4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction encoders
   function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
   endfunction

   function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'd0, rd, 7'h13};
   endfunction

   function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'd0, rs1, 3'd2, rd, 7'h03};
   endfunction

   function automatic logic [31:0] s_sw(input logic [4:0] rs2, input logic [4:0] rs1);
      return {7'd0, rs2, rs1, 3'd2, 5'd0, 7'h23};
   endfunction

   function automatic logic [31:0] csrw_x0();
      return {12'h51e, 5'd0, 3'd1, 5'd0, 7'h73};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive one decode transaction on the 2-stage instance and check it
   task automatic chk2(input string tag, input logic [31:0] inst, input logic rdr, input logic xs,
                       input int s1, input int s2, input logic st, input logic bb);
      b2.id_inst = inst; b2.id_valid = 1'b1; b2.redirect = rdr; b2.ext_stall = xs;
      #2;
      $display("txn s2 %-14s inst=%h sel=%0d/%0d stall=%b bubble=%b scnt=%0d fcnt=%0d",
               tag, inst, b2.fwd_rs1_sel, b2.fwd_rs2_sel, b2.id_stall, b2.ex_bubble,
               b2.stall_cnt, b2.flush_cnt);
      check({tag, ":rs1"},    32'(b2.fwd_rs1_sel), 32'(s1));
      check({tag, ":rs2"},    32'(b2.fwd_rs2_sel), 32'(s2));
      check({tag, ":stall"},  32'(b2.id_stall),    32'(st));
      check({tag, ":bubble"}, 32'(b2.ex_bubble),   32'(bb));
   endtask

   // Same for the 4-stage instance
   task automatic chk4(input string tag, input logic [31:0] inst,
                       input int s1, input int s2, input logic st, input logic bb);
      b4.id_inst = inst; b4.id_valid = 1'b1; b4.redirect = 1'b0; b4.ext_stall = 1'b0;
      #2;
      $display("txn s4 %-14s inst=%h sel=%0d/%0d stall=%b bubble=%b scnt=%0d",
               tag, inst, b4.fwd_rs1_sel, b4.fwd_rs2_sel, b4.id_stall, b4.ex_bubble, b4.stall_cnt);
      check({tag, ":rs1"},    32'(b4.fwd_rs1_sel), 32'(s1));
      check({tag, ":rs2"},    32'(b4.fwd_rs2_sel), 32'(s2));
      check({tag, ":stall"},  32'(b4.id_stall),    32'(st));
      check({tag, ":bubble"}, 32'(b4.ex_bubble),   32'(bb));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      b2.id_inst = '0; b2.id_valid = 1'b0; b2.redirect = 1'b0; b2.ext_stall = 1'b0;
      b4.id_inst = '0; b4.id_valid = 1'b0; b4.redirect = 1'b0; b4.ext_stall = 1'b0;
      #1 rst = 1'b0;
      #2;
      $display("txn reset sel=%0d/%0d stall=%b bubble=%b", b2.fwd_rs1_sel, b2.fwd_rs2_sel,
               b2.id_stall, b2.ex_bubble);
      check("rst:rs1",    32'(b2.fwd_rs1_sel), 32'd0);
      check("rst:rs2",    32'(b2.fwd_rs2_sel), 32'd0);
      check("rst:stall",  32'(b2.id_stall),    32'd0);
      check("rst:bubble", 32'(b2.ex_bubble),   32'd1);
      check("rst:scnt",   b2.stall_cnt,        32'd0);
      check("rst:fcnt",   b2.flush_cnt,        32'd0);
      cyc();
      rst = 1'b1;

      // ALU forwarding from stage 1 then stage 2
      chk2("addi x5",      i_addi(5'd5, 5'd0, 12'd1), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();
      chk2("add x6,x5,x5", r_add(5'd6, 5'd5, 5'd5),   1'b0, 1'b0, 1, 1, 1'b0, 1'b0); cyc();
      chk2("add x7,x5,x0", r_add(5'd7, 5'd5, 5'd0),   1'b0, 1'b0, 2, 0, 1'b0, 1'b0); cyc();

      // Load-use: one stall cycle, then forward from stage 2
      chk2("lw x5",        i_lw(5'd5, 5'd1),          1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();
      chk2("lu use",       r_add(5'd6, 5'd5, 5'd0),   1'b0, 1'b0, 1, 0, 1'b1, 1'b1); cyc();
      check("lu:scnt", b2.stall_cnt, 32'd1);
      chk2("lu release",   r_add(5'd6, 5'd5, 5'd0),   1'b0, 1'b0, 2, 0, 1'b0, 1'b0); cyc();

      // Mid-stream reset clears counters asynchronously
      rst = 1'b0;
      #1;
      check("rst2:scnt", b2.stall_cnt, 32'd0);
      rst = 1'b1;

      // Redirect beats load-use
      chk2("lw x5 b",      i_lw(5'd5, 5'd1),          1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();
      chk2("redir use",    r_add(5'd6, 5'd5, 5'd0),   1'b1, 1'b0, 1, 0, 1'b0, 1'b1); cyc();
      check("redir:fcnt", b2.flush_cnt, 32'd1);
      check("redir:scnt", b2.stall_cnt, 32'd0);
      // killed add must not occupy stage 1: x6 has no producer, x5 is in stage 2
      chk2("add x9,x6,x5", r_add(5'd9, 5'd6, 5'd5),   1'b0, 1'b0, 0, 2, 1'b0, 1'b0); cyc();

      // Youngest producer wins; stores use both sources but write nothing
      chk2("addi x5 a",    i_addi(5'd5, 5'd0, 12'd1), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();
      chk2("addi x5 b",    i_addi(5'd5, 5'd0, 12'd2), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();
      chk2("add young",    r_add(5'd6, 5'd5, 5'd5),   1'b0, 1'b0, 1, 1, 1'b0, 1'b0);
      chk2("sw x5,0(x5)",  s_sw(5'd5, 5'd5),          1'b0, 1'b0, 1, 1, 1'b0, 1'b0); cyc();
      chk2("sw again",     s_sw(5'd5, 5'd5),          1'b0, 1'b0, 2, 2, 1'b0, 1'b0); cyc();

      // rd=0 never produces; CSRW does not read rs2 (its field holds 30)
      chk2("addi x30",     i_addi(5'd30, 5'd0, 12'd0), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();
      chk2("nop",          i_addi(5'd0, 5'd0, 12'd0),  1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();
      chk2("csrw x0",      csrw_x0(),                  1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();

      // ext_stall freezes entries and counters, including a redirect cycle
      chk2("addi x5 c",    i_addi(5'd5, 5'd0, 12'd3), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();
      chk2("addi x8",      i_addi(5'd8, 5'd0, 12'd4), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();
      for (int i = 0; i < 5; i++) begin
         chk2("frozen", r_add(5'd10, 5'd5, 5'd8), (i == 2), 1'b1, 2, 1, 1'b0, (i == 2)); cyc();
      end
      check("frz:fcnt", b2.flush_cnt, 32'd1);
      chk2("thaw",         r_add(5'd10, 5'd5, 5'd8),  1'b0, 1'b0, 2, 1, 1'b0, 1'b0); cyc();
      chk2("add x11",      r_add(5'd11, 5'd10, 5'd8), 1'b0, 1'b0, 1, 2, 1'b0, 1'b0);

      // Asynchronous reset with no clock edge
      rst = 1'b0;
      #1;
      check("arst:rs1",  32'(b2.fwd_rs1_sel), 32'd0);
      check("arst:rs2",  32'(b2.fwd_rs2_sel), 32'd0);
      check("arst:fcnt", b2.flush_cnt,        32'd0);
      check("arst:scnt", b2.stall_cnt,        32'd0);
      rst = 1'b1;
      #1;
      chk2("first post",   r_add(5'd11, 5'd10, 5'd8), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0); cyc();
      b2.id_valid = 1'b0;

      // Deeper pipe, LOAD_LAT=2: use two cycles after lw stalls once, then stage 3
      chk4("lw x3",        i_lw(5'd3, 5'd1),          0, 0, 1'b0, 1'b0); cyc();
      chk4("addi x9",      i_addi(5'd9, 5'd0, 12'd0), 0, 0, 1'b0, 1'b0); cyc();
      chk4("use x3",       r_add(5'd4, 5'd3, 5'd0),   2, 0, 1'b1, 1'b1); cyc();
      check("s4:scnt", b4.stall_cnt, 32'd1);
      chk4("use x3 rel",   r_add(5'd4, 5'd3, 5'd0),   3, 0, 1'b0, 1'b0); cyc();
      b4.id_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
